// File: rtl/uart_r.sv
// rtl/uart_r.sv - memory-mapped 8N1 UART receiver with byte FIFO and status flags
module uart_r #(
    parameter logic [31:0] DIV_RESET = 32'd1,
    parameter int          FIFO_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam logic [FIFO_LOG2:0] FULL_CNT = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_n;
    logic [31:0]            clk_div;
    logic [31:0]            cnt, cnt_n;
    logic [2:0]             bitn, bitn_n;
    logic [7:0]             shreg, shreg_n;
    logic                   rx_meta, rx_s;
    logic                   push, ferr_set;
    logic                   overrun, frame_err;

    logic [7:0]             mem [DEPTH];
    logic [FIFO_LOG2-1:0]   wptr, rptr;
    logic [FIFO_LOG2:0]     count;

    logic                   rd, wr, empty, full, pop, push_ok, ovr_set;
    logic                   unused_ok;

    assign unused_ok = &{1'b0, addr[31:8]};
    assign rd        = sel && !wen;
    assign wr        = sel && wen;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign pop       = rd && (addr[7:0] == 8'h00) && !empty;
    // A full FIFO still accepts a byte when a pop frees the head slot on the same edge.
    assign push_ok   = push && (!full || pop);
    assign ovr_set   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
        bitn_n   = bitn;
        shreg_n  = shreg;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = cnt;
                if (!rx_s) begin
                    cnt_n   = clk_div >> 1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == 32'd0) begin
                    if (!rx_s) begin
                        cnt_n   = clk_div;
                        bitn_n  = 3'd0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == 32'd0) begin
                    shreg_n = {rx_s, shreg[7:1]};
                    cnt_n   = clk_div;
                    bitn_n  = bitn + 3'd1;
                    if (bitn == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == 32'd0) begin
                    push     = rx_s;
                    ferr_set = !rx_s;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 32'd0;
            bitn  <= 3'd0;
            shreg <= 8'd0;
        end else begin
            state <= state_n;
            bitn  <= bitn_n;
            shreg <= shreg_n;
            cnt   <= (wr && addr[7:0] == 8'h04) ? wdata : cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_div   <= DIV_RESET;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr && addr[7:0] == 8'h04) clk_div <= wdata;
            // A new error in the same cycle as a clear keeps the flag set.
            if (ovr_set)                       overrun <= 1'b1;
            else if (wr && addr[7:0] == 8'h08) overrun <= 1'b0;
            if (ferr_set)                      frame_err <= 1'b1;
            else if (wr && addr[7:0] == 8'h08) frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'd0;
        end else if (rd) begin
            case (addr[7:0])
                8'h00:   rdata <= empty ? 32'd0 : {24'd0, mem[rptr]};
                8'h04:   rdata <= clk_div;
                8'h08:   rdata <= {29'd0, frame_err, overrun, !empty};
                default: rdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_r.sv
// tb/tb_uart_r.sv - scoreboard bench for uart_r against a byte-level receiver model
module tb_uart_r;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        rx = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] addr_q [$];

    logic [7:0]  m_fifo [$];
    logic        m_ovr = 1'b0;
    logic        m_ferr = 1'b0;
    int          m_div = 1;

    uart_r #(.DIV_RESET(32'd1), .FIFO_LOG2(4)) dut (
        .clk(clk), .reset(reset), .sel(sel), .wen(wen),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rx(rx)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, pending=%0d required=0", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: every read access is answered by rdata after the next edge.
    initial begin
        logic [31:0] e, a;
        forever begin
            @(posedge clk);
            if (sel && !wen) begin
                @(negedge clk);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: got %h required no read", rdata);
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    if (rdata !== e) begin
                        errors++;
                        $display("FAIL read_%h: got %h required %h", a[7:0], rdata, e);
                    end
                end
            end
        end
    end

    task automatic bus_read(input logic [31:0] a);
        logic [31:0] e;
        case (a[7:0])
            8'h00:   e = (m_fifo.size() != 0) ? {24'd0, m_fifo.pop_front()} : 32'd0;
            8'h04:   e = 32'(m_div);
            8'h08:   e = {29'd0, m_ferr, m_ovr, m_fifo.size() != 0};
            default: e = 32'd0;
        endcase
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(posedge clk); #1;
        sel = 1'b1; wen = 1'b0; addr = a;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        if (a[7:0] == 8'h04) m_div = int'(d);
        if (a[7:0] == 8'h08) begin m_ovr = 1'b0; m_ferr = 1'b0; end
        @(posedge clk); #1;
        sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; wen = 1'b0;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rx = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        int p;
        p = m_div + 1;
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(b[i], p);
        drive(stop_ok, p);
        drive(1'b1, 2 * p + 4);
        if (!stop_ok)                m_ferr = 1'b1;
        else if (m_fifo.size() == 16) m_ovr = 1'b1;
        else                          m_fifo.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; rx = 1'b1; sel = 1'b0; wen = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_fifo.delete();
        m_ovr = 1'b0; m_ferr = 1'b0; m_div = 1;
    endtask

    initial begin
        logic [7:0] b;
        int nf, nr;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required %h", rdata, 32'd0);
        end
        reset = 1'b0;
        bus_read(32'h08);
        bus_read(32'h04);
        bus_read(32'h40);

        bus_write(32'h04, 32'd3);
        send_frame(8'hA5, 1'b1);
        bus_read(32'h08);
        bus_read(32'h00);
        bus_read(32'h08);
        bus_read(32'h00);

        send_frame(8'h3C, 1'b0);
        bus_read(32'h08);
        bus_write(32'h08, 32'd0);
        bus_read(32'h08);

        bus_write(32'h04, 32'd7);
        drive(1'b0, 2);
        drive(1'b1, 20);
        bus_read(32'h08);

        bus_write(32'h04, 32'd3);
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        bus_read(32'h08);
        for (int i = 0; i < 17; i++) bus_read(32'h00);
        bus_read(32'h08);
        bus_write(32'h08, 32'd0);

        // Abort in the middle of data bit 4, then a clean frame at the reset divider.
        drive(1'b0, 4);
        b = 8'h5A;
        for (int i = 0; i < 4; i++) drive(b[i], 4);
        drive(b[4], 2);
        do_reset();
        drive(1'b1, 6);
        bus_read(32'h08);
        send_frame(8'h5A, 1'b1);
        bus_read(32'h08);
        bus_read(32'h00);

        bus_write(32'h04, 32'd4);
        bus_read(32'h04);
        send_frame(8'h81, 1'b1);
        bus_read(32'h00);
        bus_read(32'h08);

        for (int it = 0; it < 20; it++) begin
            bus_write(32'h04, $urandom_range(8, 1));
            nf = $urandom_range(3, 1);
            for (int f = 0; f < nf; f++)
                send_frame(8'($urandom), ($urandom_range(9, 0) != 0));
            nr = $urandom_range(3, 0);
            for (int r = 0; r < nr; r++) bus_read(32'h00);
            bus_read(32'h08);
            if ($urandom_range(3, 0) == 0) bus_write(32'h08, 32'd0);
        end
        for (int r = 0; r < 17; r++) bus_read(32'h00);
        bus_read(32'h08);

        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL unanswered_reads: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
